// File: rtl/hsst2ad_fifo_rd_stream.sv
// hsst2ad_fifo_rd_stream
//   Read-side drain engine for the HSST-to-AD clock-crossing FIFO. Issues
//   FIFO reads against a credit made up of local buffer occupancy plus reads
//   still travelling through the FIFO read latency, then captures landed
//   words into a small circular buffer. The buffer head is presented as a
//   valid/ready stream, which gives first-word-fall-through behaviour at
//   full throughput with no loss under backpressure.
//
// Ports
//   rd_clk, rd_rst       FIFO read clock, async active-high reset
//   drain_en             permit new FIFO reads
//   fifo_rd_en           FIFO read enable
//   fifo_rd_oce          FIFO output-register enable
//   fifo_rd_data         FIFO read data
//   fifo_rd_empty        FIFO empty flag
//   m_data/m_valid/m_ready  output stream
//   buf_level            occupied buffer entries
//   word_cnt             accepted stream transfers (wraps)
module hsst2ad_fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic                         drain_en,
  output logic                         fifo_rd_en,
  output logic                         fifo_rd_oce,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                         fifo_rd_empty,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(BUF_DEPTH):0]   buf_level,
  output logic [31:0]                  word_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 2;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [CW-1:0]         inflight, credit_used;
  logic                  land, pop;

  // Reads issued but not yet landed.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Credit ignores a same-cycle pop: costs at most one bubble after a stall,
  // but keeps rd_en free of any path from m_ready.
  assign credit_used = CW'(buf_level) + inflight;
  assign fifo_rd_en  = ~rd_rst & drain_en & ~fifo_rd_empty &
                       (credit_used < CW'(BUF_DEPTH));

  assign land    = vld_pipe[RD_LATENCY-1];
  assign m_valid = (buf_level != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem[rd_ptr];

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign fifo_rd_oce = 1'b1;
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) vld_pipe <= '0;
        else        vld_pipe <= fifo_rd_en;
      end
    end else begin : g_latn
      // Output register advances only when a read occupies the first stage.
      assign fifo_rd_oce = vld_pipe[0];
      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[RD_LATENCY-2:0], fifo_rd_en};
      end
    end
  endgenerate

  // Buffer, pointers, level and transfer count. Contents are cleared on reset
  // so m_data reads 0 while idle after reset.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_level <= '0;
      word_cnt  <= '0;
    end else begin
      if (land) begin
        mem[wr_ptr] <= fifo_rd_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        word_cnt <= word_cnt + 32'd1;
      end
      case ({land, pop})
        2'b10:   buf_level <= buf_level + 1'b1;
        2'b01:   buf_level <= buf_level - 1'b1;
        default: buf_level <= buf_level;
      endcase
    end
  end

endmodule

// File: tb/tb_hsst2ad_fifo_rd_stream.sv
// Bench for hsst2ad_fifo_rd_stream: two instances (RD_LATENCY 1 and 2) share
// one FIFO model; sel picks the active one, the other sees an empty FIFO.
module tb_hsst2ad_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        drain_en = 1'b0;
  logic        m_ready = 1'b0;
  logic        sel = 1'b0;

  // FIFO model
  logic [31:0] fmem [0:1023];
  int          wp = 0;
  int          rp = 0;
  logic [31:0] s1, s2;
  logic        fifo_empty;
  assign fifo_empty = (wp == rp);

  logic        en1, oce1, vld1, en2, oce2, vld2, e1, e2;
  logic [31:0] d1, d2, wc1, wc2;
  logic [2:0]  bl1, bl2;
  assign e1 = fifo_empty | sel;
  assign e2 = fifo_empty | ~sel;

  logic        rd_en, oce, mv;
  logic [31:0] md, wc;
  logic [2:0]  bl;
  assign rd_en = sel ? en2  : en1;
  assign oce   = sel ? oce2 : oce1;
  assign mv    = sel ? vld2 : vld1;
  assign md    = sel ? d2   : d1;
  assign wc    = sel ? wc2  : wc1;
  assign bl    = sel ? bl2  : bl1;

  hsst2ad_fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(1), .BUF_DEPTH(4)) u_l1 (
    .rd_clk(clk), .rd_rst(rst), .drain_en(drain_en & ~sel),
    .fifo_rd_en(en1), .fifo_rd_oce(oce1), .fifo_rd_data(s1), .fifo_rd_empty(e1),
    .m_data(d1), .m_valid(vld1), .m_ready(m_ready), .buf_level(bl1), .word_cnt(wc1));

  hsst2ad_fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(2), .BUF_DEPTH(4)) u_l2 (
    .rd_clk(clk), .rd_rst(rst), .drain_en(drain_en & sel),
    .fifo_rd_en(en2), .fifo_rd_oce(oce2), .fifo_rd_data(s2), .fifo_rd_empty(e2),
    .m_data(d2), .m_valid(vld2), .m_ready(m_ready), .buf_level(bl2), .word_cnt(wc2));

  // FIFO read port: stage 1 is the RAM read, stage 2 the optional output register.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      rp <= wp;
    end else begin
      if (rd_en && !fifo_empty) begin
        s1 <= fmem[rp];
        rp <= rp + 1;
      end
      if (oce) s2 <= s1;
    end
  end

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] sb [$];

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      n_asrt++;
      if (bl1 > 3'd4 || bl2 > 3'd4) begin
        n_fail++;
        $display("FAIL buf_level_bound: l1=%0d l2=%0d required <= 4", bl1, bl2);
      end
      n_asrt++;
      if ((en1 && e1) || (en2 && e2)) begin
        n_fail++;
        $display("FAIL rd_en_while_empty: en1=%0d e1=%0d en2=%0d e2=%0d", en1, e1, en2, e2);
      end
      if (mv && m_ready) begin
        n_asrt++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra_word: got %h, none required", md);
        end else begin
          logic [31:0] exp;
          exp = sb.pop_front();
          if (md !== exp) begin
            n_fail++;
            $display("FAIL stream_data: got %h required %h", md, exp);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    fmem[wp] = d;
    wp = wp + 1;
    sb.push_back(d);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drain_en = 1'b0;
    m_ready = 1'b0;
    sb.delete();
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drain_en = 1'b1;
    m_ready = 1'b1;
    tick;
    @(negedge clk);
    n_asrt++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en_l1: got %0d required 0", en1); end
    n_asrt++; if (oce1 !== 1'b1) begin n_fail++; $display("FAIL reset_oce_l1: got %0d required 1", oce1); end
    n_asrt++; if (oce2 !== 1'b0) begin n_fail++; $display("FAIL reset_oce_l2: got %0d required 0", oce2); end
    n_asrt++; if (vld1 !== 1'b0 || vld2 !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0d/%0d required 0/0", vld1, vld2); end
    n_asrt++; if (d1 !== 32'd0 || d2 !== 32'd0) begin n_fail++; $display("FAIL reset_m_data: got %h/%h required 0", d1, d2); end
    n_asrt++; if (bl1 !== 3'd0 || bl2 !== 3'd0) begin n_fail++; $display("FAIL reset_buf_level: got %0d/%0d required 0", bl1, bl2); end
    n_asrt++; if (wc1 !== 32'd0 || wc2 !== 32'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d/%0d required 0", wc1, wc2); end
    do_reset;
  endtask

  task automatic test_single;
    int en_cnt, v_cnt, first;
    sel = 1'b0;
    do_reset;
    drain_en = 1'b1;
    m_ready = 1'b1;
    en_cnt = 0; v_cnt = 0; first = -1;
    write_word(32'hA5A5_0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (en1) en_cnt++;
      if (vld1) begin
        v_cnt++;
        if (first < 0) first = i;
      end
    end
    n_asrt++; if (en_cnt != 1) begin n_fail++; $display("FAIL single_rd_en_pulses: got %0d required 1", en_cnt); end
    n_asrt++; if (v_cnt != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d required 1", v_cnt); end
    n_asrt++; if (first != 2) begin n_fail++; $display("FAIL single_first_cycle: got %0d required 2", first); end
    n_asrt++; if (wc1 !== 32'd1) begin n_fail++; $display("FAIL single_word_cnt: got %0d required 1", wc1); end
  endtask

  task automatic test_stream;
    int v_cnt, first, last;
    sel = 1'b1;
    do_reset;
    drain_en = 1'b1;
    m_ready = 1'b1;
    v_cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 64; i++) write_word(32'h0000_1000 + i);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (vld2) begin
        v_cnt++;
        last = i;
        if (first < 0) first = i;
      end
    end
    n_asrt++; if (first != 3) begin n_fail++; $display("FAIL stream_first_cycle: got %0d required 3", first); end
    n_asrt++; if (v_cnt != 64) begin n_fail++; $display("FAIL stream_valid_cycles: got %0d required 64", v_cnt); end
    n_asrt++; if (last - first != 63) begin n_fail++; $display("FAIL stream_bubbles: span %0d required 63", last - first); end
    n_asrt++; if (wc2 !== 32'd64) begin n_fail++; $display("FAIL stream_word_cnt: got %0d required 64", wc2); end
    n_asrt++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_undelivered: got %0d required 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    int issued, maxl;
    sel = 1'b0;
    do_reset;
    drain_en = 1'b1;
    m_ready = 1'b0;
    issued = 0; maxl = 0;
    for (int i = 0; i < 16; i++) write_word($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en1) issued++;
      if (int'(bl1) > maxl) maxl = int'(bl1);
    end
    n_asrt++; if (issued != 4) begin n_fail++; $display("FAIL bp_reads_during_stall: got %0d required 4", issued); end
    n_asrt++; if (maxl != 4) begin n_fail++; $display("FAIL bp_max_level: got %0d required 4", maxl); end
    tick;
    m_ready = 1'b1;
    @(negedge clk);
    n_asrt++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL bp_release_accept: got %0d required 1", vld1); end
    n_asrt++; if (en1 !== 1'b0) begin n_fail++; $display("FAIL bp_release_no_issue: got %0d required 0", en1); end
    tick;
    @(negedge clk);
    n_asrt++; if (en1 !== 1'b1) begin n_fail++; $display("FAIL bp_resume_issue: got %0d required 1", en1); end
    for (int i = 0; i < 400 && wc1 != 32'd16; i++) begin
      tick;
      m_ready = 1'($urandom_range(0, 1));
    end
    tick;
    m_ready = 1'b0;
    @(negedge clk);
    n_asrt++; if (wc1 !== 32'd16) begin n_fail++; $display("FAIL bp_word_cnt: got %0d required 16", wc1); end
    n_asrt++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_undelivered: got %0d required 0", sb.size()); end
  endtask

  task automatic test_pause;
    int en_cnt;
    sel = 1'b1;
    do_reset;
    m_ready = 1'b1;
    drain_en = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) write_word(32'h0000_2000 + i);
    tick;
    tick;
    tick;
    drain_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (en2) en_cnt++;
    end
    n_asrt++; if (en_cnt != 0) begin n_fail++; $display("FAIL pause_rd_en: got %0d cycles required 0", en_cnt); end
    n_asrt++; if (wc2 !== 32'd3) begin n_fail++; $display("FAIL pause_delivered: got %0d required 3", wc2); end
    n_asrt++; if (sb.size() != 7) begin n_fail++; $display("FAIL pause_pending: got %0d required 7", sb.size()); end
    tick;
    drain_en = 1'b1;
    for (int i = 0; i < 100 && wc2 != 32'd10; i++) tick;
    @(negedge clk);
    n_asrt++; if (wc2 !== 32'd10) begin n_fail++; $display("FAIL pause_resume_cnt: got %0d required 10", wc2); end
    n_asrt++; if (sb.size() != 0) begin n_fail++; $display("FAIL pause_undelivered: got %0d required 0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    int v_cnt;
    sel = 1'b1;
    do_reset;
    m_ready = 1'b0;
    drain_en = 1'b1;
    v_cnt = 0;
    for (int i = 0; i < 8; i++) write_word(32'h0000_3000 + i);
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_asrt++; if (bl2 !== 3'd2) begin n_fail++; $display("FAIL mid_pre_level: got %0d required 2", bl2); end
    n_asrt++; if (vld2 !== 1'b1 || d2 !== 32'h0000_3000) begin n_fail++; $display("FAIL mid_pre_head: got %0d/%h required 1/00003000", vld2, d2); end
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    n_asrt++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0d required 0", vld2); end
    n_asrt++; if (d2 !== 32'd0) begin n_fail++; $display("FAIL mid_rst_data: got %h required 0", d2); end
    n_asrt++; if (bl2 !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d required 0", bl2); end
    n_asrt++; if (en2 !== 1'b0 || oce2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd: got en=%0d oce=%0d required 0/0", en2, oce2); end
    n_asrt++; if (wc2 !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d required 0", wc2); end
    tick;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld2) v_cnt++;
    end
    n_asrt++; if (v_cnt != 0) begin n_fail++; $display("FAIL mid_post_valid: got %0d cycles required 0", v_cnt); end
  endtask

  task automatic test_wrap;
    sel = 1'b0;
    do_reset;
    force u_l1.word_cnt = 32'hFFFF_FFFE;
    #1;
    release u_l1.word_cnt;
    @(negedge clk);
    n_asrt++; if (wc1 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_preload: got %h required fffffffe", wc1); end
    tick;
    drain_en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(32'h0000_4000 + i);
    for (int i = 0; i < 10; i++) tick;
    @(negedge clk);
    n_asrt++; if (wc1 !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_word_cnt: got %h required 00000001", wc1); end
    n_asrt++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_undelivered: got %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_pause;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
